// File: rtl/mem_wb_skid_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_reg
//
// Purpose:
//    Two-entry elastic pipeline register between the memory stage and
//    write-back. A head entry drives the outputs and a skid entry catches one
//    extra bundle. Because in_ready depends only on registered state, there
//    is no combinational path from out_ready back to the producer. Bundle
//    order is strictly FIFO.
//
// Ports:
//    clk, rst                   clock and synchronous active-high reset
//    in_valid / in_ready        upstream handshake (EXE side)
//    WB_EN_EXE, MEM_R_EN_EXE    incoming write-back enable / memory-read flag
//    alu_res_EXE, data_mem      incoming ALU result and memory read data
//    dest_EXE                   incoming destination register index
//    flush                      discard every held bundle
//    out_valid / out_ready      downstream handshake (write-back side)
//    WB_EN_MEM ... dest_MEM     fields of the head bundle
//    occupancy                  number of held bundles (0..2)
// ---------------------------------------------------------------------------
module mem_wb_skid_reg #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              WB_EN_EXE,
   input  logic              MEM_R_EN_EXE,
   input  logic [DATA_W-1:0] alu_res_EXE,
   input  logic [DATA_W-1:0] data_mem,
   input  logic [DEST_W-1:0] dest_EXE,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              WB_EN_MEM,
   output logic              MEM_R_EN_MEM,
   output logic [DATA_W-1:0] alu_res_MEM,
   output logic [DATA_W-1:0] data_mem_MEM,
   output logic [DEST_W-1:0] dest_MEM,
   output logic [1:0]        occupancy
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;

   logic                r_headWbEn;
   logic                r_headMemREn;
   logic [DATA_W-1:0]   r_headAlu;
   logic [DATA_W-1:0]   r_headDmem;
   logic [DEST_W-1:0]   r_headDest;

   logic                r_skidWbEn;
   logic                r_skidMemREn;
   logic [DATA_W-1:0]   r_skidAlu;
   logic [DATA_W-1:0]   r_skidDmem;
   logic [DEST_W-1:0]   r_skidDest;

   logic                w_accept;
   logic                w_consume;

   // Handshakes are derived from the registered state only, so FULL can never
   // accept and EMPTY can never present a bundle.
   assign w_accept  = in_valid  & (r_state != FULL);
   assign w_consume = out_ready & (r_state != EMPTY);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Flush overrides every handshake in its cycle; a bundle
   // offered then is dropped, and one consumed then counts as delivered.
   always_comb begin
      w_nextState = r_state;
      if (flush) begin
         w_nextState = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) w_nextState = ONE;
            end
            ONE: begin
               if (w_accept && !w_consume)      w_nextState = FULL;
               else if (!w_accept && w_consume) w_nextState = EMPTY;
               else                             w_nextState = ONE;
            end
            FULL: begin
               if (w_consume) w_nextState = ONE;
            end
            default: w_nextState = EMPTY;
         endcase
      end
   end

   // Data path. The head is loaded from the input whenever it is empty or
   // being consumed at the same edge; otherwise a new bundle lands in the skid
   // entry. When FULL drains, the skid entry moves forward into the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_headWbEn   <= 1'b0;
         r_headMemREn <= 1'b0;
         r_headAlu    <= '0;
         r_headDmem   <= '0;
         r_headDest   <= '0;
         r_skidWbEn   <= 1'b0;
         r_skidMemREn <= 1'b0;
         r_skidAlu    <= '0;
         r_skidDmem   <= '0;
         r_skidDest   <= '0;
      end else if (!flush) begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_headWbEn   <= WB_EN_EXE;
                  r_headMemREn <= MEM_R_EN_EXE;
                  r_headAlu    <= alu_res_EXE;
                  r_headDmem   <= data_mem;
                  r_headDest   <= dest_EXE;
               end
            end
            ONE: begin
               if (w_accept && w_consume) begin
                  r_headWbEn   <= WB_EN_EXE;
                  r_headMemREn <= MEM_R_EN_EXE;
                  r_headAlu    <= alu_res_EXE;
                  r_headDmem   <= data_mem;
                  r_headDest   <= dest_EXE;
               end else if (w_accept) begin
                  r_skidWbEn   <= WB_EN_EXE;
                  r_skidMemREn <= MEM_R_EN_EXE;
                  r_skidAlu    <= alu_res_EXE;
                  r_skidDmem   <= data_mem;
                  r_skidDest   <= dest_EXE;
               end
            end
            FULL: begin
               if (w_consume) begin
                  r_headWbEn   <= r_skidWbEn;
                  r_headMemREn <= r_skidMemREn;
                  r_headAlu    <= r_skidAlu;
                  r_headDmem   <= r_skidDmem;
                  r_headDest   <= r_skidDest;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs. The control flags are masked so write-back never sees a stale
   // enable while the register is empty; the data fields are passed through
   // unmasked.
   always_comb begin
      in_ready     = (r_state != FULL);
      out_valid    = (r_state != EMPTY);
      occupancy    = r_state;
      WB_EN_MEM    = r_headWbEn   & (r_state != EMPTY);
      MEM_R_EN_MEM = r_headMemREn & (r_state != EMPTY);
      alu_res_MEM  = r_headAlu;
      data_mem_MEM = r_headDmem;
      dest_MEM     = r_headDest;
   end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_skid_reg
//
// Self-checking bench for mem_wb_skid_reg. A default-width instance is driven
// from a table of directed vectors. Each vector lists the inputs for one clock
// edge and the outputs expected just after that edge. A second instance with
// DATA_W=64 and DEST_W=5 is exercised by a hand-written pass-through sequence.
// A further hand-written sequence checks that in_ready ignores out_ready and
// that held data stays put.
// ---------------------------------------------------------------------------
module tb_mem_wb_skid_reg;

   logic        clk = 1'b0;

   // Default-width DUT signals.
   logic        rst, flush, inValid, outReady;
   logic        wbEnIn, memRIn;
   logic [31:0] aluIn, dmemIn;
   logic [3:0]  destIn;
   logic        inReady, outValid, wbEnOut, memROut;
   logic [31:0] aluOut, dmemOut;
   logic [3:0]  destOut;
   logic [1:0]  occ;

   // Wide DUT signals.
   logic        rst64, flush64, inValid64, outReady64;
   logic        wbEnIn64, memRIn64;
   logic [63:0] aluIn64, dmemIn64;
   logic [4:0]  destIn64;
   logic        inReady64, outValid64, wbEnOut64, memROut64;
   logic [63:0] aluOut64, dmemOut64;
   logic [4:0]  destOut64;
   logic [1:0]  occ64;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mem_wb_skid_reg dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
      .WB_EN_EXE(wbEnIn), .MEM_R_EN_EXE(memRIn), .alu_res_EXE(aluIn),
      .data_mem(dmemIn), .dest_EXE(destIn), .flush(flush),
      .out_valid(outValid), .out_ready(outReady), .WB_EN_MEM(wbEnOut),
      .MEM_R_EN_MEM(memROut), .alu_res_MEM(aluOut), .data_mem_MEM(dmemOut),
      .dest_MEM(destOut), .occupancy(occ)
   );

   mem_wb_skid_reg #(.DATA_W(64), .DEST_W(5)) dut64 (
      .clk(clk), .rst(rst64), .in_valid(inValid64), .in_ready(inReady64),
      .WB_EN_EXE(wbEnIn64), .MEM_R_EN_EXE(memRIn64), .alu_res_EXE(aluIn64),
      .data_mem(dmemIn64), .dest_EXE(destIn64), .flush(flush64),
      .out_valid(outValid64), .out_ready(outReady64), .WB_EN_MEM(wbEnOut64),
      .MEM_R_EN_MEM(memROut64), .alu_res_MEM(aluOut64),
      .data_mem_MEM(dmemOut64), .dest_MEM(destOut64), .occupancy(occ64)
   );

   // One table row: inputs for an edge plus the outputs expected after it.
   // chkData clears when the data fields are don't-care (nothing held).
   typedef struct packed {
      logic        rst;
      logic        flush;
      logic        inValid;
      logic        wbEn;
      logic        memR;
      logic [31:0] alu;
      logic [3:0]  dest;
      logic        outReady;
      logic        eInReady;
      logic        eOutValid;
      logic [1:0]  eOcc;
      logic        eWbEn;
      logic        eMemR;
      logic [31:0] eAlu;
      logic [3:0]  eDest;
      logic        chkData;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   function automatic vec_t mkVec(
      input logic r, input logic f, input logic iv, input logic wb,
      input logic mr, input logic [31:0] a, input logic [3:0] d,
      input logic orr, input logic eir, input logic eov, input logic [1:0] eocc,
      input logic ewb, input logic emr, input logic [31:0] ea,
      input logic [3:0] ed, input logic chk);
      vec_t v;
      v.rst = r;        v.flush = f;       v.inValid = iv;
      v.wbEn = wb;      v.memR = mr;       v.alu = a;
      v.dest = d;       v.outReady = orr;  v.eInReady = eir;
      v.eOutValid = eov; v.eOcc = eocc;    v.eWbEn = ewb;
      v.eMemR = emr;    v.eAlu = ea;       v.eDest = ed;
      v.chkData = chk;
      return v;
   endfunction

   // data_mem is derived from the ALU value so that both data fields are
   // distinct yet predictable; a zero ALU value maps to zero read data.
   function automatic logic [31:0] dmemOf(input logic [31:0] a);
      return {a[15:0], a[15:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drives one vector, lets one rising edge pass, then samples the outputs
   // 1 ns after the edge.
   task automatic applyStimulus(input vec_t v);
      rst      = v.rst;
      flush    = v.flush;
      inValid  = v.inValid;
      wbEnIn   = v.wbEn;
      memRIn   = v.memR;
      aluIn    = v.alu;
      dmemIn   = dmemOf(v.alu);
      destIn   = v.dest;
      outReady = v.outReady;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      checkOutput({tag, ".in_ready"},  64'(inReady),  64'(v.eInReady));
      checkOutput({tag, ".out_valid"}, 64'(outValid), 64'(v.eOutValid));
      checkOutput({tag, ".occupancy"}, 64'(occ),      64'(v.eOcc));
      checkOutput({tag, ".WB_EN_MEM"}, 64'(wbEnOut),  64'(v.eWbEn));
      checkOutput({tag, ".MEM_R_EN"},  64'(memROut),  64'(v.eMemR));
      if (v.chkData) begin
         checkOutput({tag, ".alu_res"},  64'(aluOut),  64'(v.eAlu));
         checkOutput({tag, ".data_mem"}, 64'(dmemOut), 64'(dmemOf(v.eAlu)));
         checkOutput({tag, ".dest"},     64'(destOut), 64'(v.eDest));
      end
   endtask

   task automatic drive64(input logic iv, input logic [63:0] a,
                          input logic [4:0] d, input logic orr);
      inValid64  = iv;
      wbEnIn64   = 1'b1;
      memRIn64   = a[0];
      aluIn64    = a;
      dmemIn64   = ~a;
      destIn64   = d;
      outReady64 = orr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Columns: rst flush iv wb mr alu dest oR | iR oV occ wb mr alu dest chk
      // Reset held two cycles, then idle outputs.
      vecs[0]  = mkVec(1,0,0,0,0,32'h0,   4'h0,0, 1,0,2'd0,0,0,32'h0,   4'h0,1);
      vecs[1]  = mkVec(1,0,0,0,0,32'h0,   4'h0,0, 1,0,2'd0,0,0,32'h0,   4'h0,1);
      // Back-to-back pass-through with out_ready high.
      vecs[2]  = mkVec(0,0,1,1,0,32'h11,  4'h1,1, 1,1,2'd1,1,0,32'h11,  4'h1,1);
      vecs[3]  = mkVec(0,0,1,1,1,32'h22,  4'h2,1, 1,1,2'd1,1,1,32'h22,  4'h2,1);
      vecs[4]  = mkVec(0,0,1,0,0,32'h33,  4'h3,1, 1,1,2'd1,0,0,32'h33,  4'h3,1);
      vecs[5]  = mkVec(0,0,0,0,0,32'h0,   4'h0,1, 1,0,2'd0,0,0,32'h0,   4'h0,0);
      // Backpressure: A, B fill; C is offered but refused.
      vecs[6]  = mkVec(0,0,1,1,0,32'hA,   4'hA,0, 1,1,2'd1,1,0,32'hA,   4'hA,1);
      vecs[7]  = mkVec(0,0,1,1,0,32'hB,   4'hB,0, 0,1,2'd2,1,0,32'hA,   4'hA,1);
      vecs[8]  = mkVec(0,0,1,1,0,32'hC,   4'hC,0, 0,1,2'd2,1,0,32'hA,   4'hA,1);
      // Release: A leaves, B moves up; C still refused while FULL.
      vecs[9]  = mkVec(0,0,1,1,0,32'hC,   4'hC,1, 1,1,2'd1,1,0,32'hB,   4'hB,1);
      vecs[10] = mkVec(0,0,1,1,0,32'hC,   4'hC,1, 1,1,2'd1,1,0,32'hC,   4'hC,1);
      vecs[11] = mkVec(0,0,0,0,0,32'h0,   4'h0,1, 1,0,2'd0,0,0,32'h0,   4'h0,0);
      // Flush while FULL with 0xD offered.
      vecs[12] = mkVec(0,0,1,1,1,32'h1,   4'h1,0, 1,1,2'd1,1,1,32'h1,   4'h1,1);
      vecs[13] = mkVec(0,0,1,1,1,32'h2,   4'h2,0, 0,1,2'd2,1,1,32'h1,   4'h1,1);
      vecs[14] = mkVec(0,1,1,1,1,32'hD,   4'hD,0, 1,0,2'd0,0,0,32'h0,   4'h0,0);
      vecs[15] = mkVec(0,0,0,0,0,32'h0,   4'h0,1, 1,0,2'd0,0,0,32'h0,   4'h0,0);
      // Simultaneous accept and consume in ONE.
      vecs[16] = mkVec(0,0,1,1,0,32'h5,   4'h5,0, 1,1,2'd1,1,0,32'h5,   4'h5,1);
      vecs[17] = mkVec(0,0,1,1,0,32'h6,   4'h6,1, 1,1,2'd1,1,0,32'h6,   4'h6,1);
      // Flush in ONE with both accept and consume pending.
      vecs[18] = mkVec(0,1,1,1,0,32'h7,   4'h7,1, 1,0,2'd0,0,0,32'h0,   4'h0,0);
      // Reset while FULL, with everything else asserted.
      vecs[19] = mkVec(0,0,1,1,1,32'h8,   4'h8,0, 1,1,2'd1,1,1,32'h8,   4'h8,1);
      vecs[20] = mkVec(0,0,1,1,1,32'h9,   4'h9,0, 0,1,2'd2,1,1,32'h8,   4'h8,1);
      vecs[21] = mkVec(1,1,1,1,1,32'hE,   4'hE,1, 1,0,2'd0,0,0,32'h0,   4'h0,1);
      vecs[22] = mkVec(0,0,0,0,0,32'h0,   4'h0,0, 1,0,2'd0,0,0,32'h0,   4'h0,1);

      // Hold the wide instance in reset while the table runs.
      rst64 = 1'b1; flush64 = 1'b0; inValid64 = 1'b0; outReady64 = 1'b0;
      wbEnIn64 = 1'b0; memRIn64 = 1'b0; aluIn64 = '0; dmemIn64 = '0;
      destIn64 = '0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Fill to FULL, then check in_ready does not follow out_ready
      // combinationally and that held data is stable over idle cycles.
      applyStimulus(mkVec(0,0,1,1,0,32'h40,4'h4,0, 1,1,2'd1,1,0,32'h40,4'h4,1));
      applyStimulus(mkVec(0,0,1,0,1,32'h50,4'h5,0, 0,1,2'd2,1,0,32'h40,4'h4,1));
      inValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checkOutput("hold.alu_res",   64'(aluOut), 64'h40);
         checkOutput("hold.occupancy", 64'(occ),    64'd2);
      end
      outReady = 1'b1;
      #1;
      checkOutput("full.in_ready_no_comb", 64'(inReady), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("drain.alu_res", 64'(aluOut),  64'h50);
      checkOutput("drain.memr",    64'(memROut), 64'd1);
      checkOutput("drain.wben",    64'(wbEnOut), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("drain.out_valid", 64'(outValid), 64'd0);

      // Wide build: reset two cycles, then pass three 64-bit bundles through.
      drive64(1'b0, 64'h0, 5'h0, 1'b0);
      drive64(1'b0, 64'h0, 5'h0, 1'b0);
      checkOutput("w64.reset_occ", 64'(occ64),    64'd0);
      checkOutput("w64.reset_alu", aluOut64,      64'h0);
      rst64 = 1'b0;
      drive64(1'b1, 64'hDEAD_BEEF_0000_0011, 5'h11, 1'b1);
      checkOutput("w64.p1_alu",  aluOut64,         64'hDEAD_BEEF_0000_0011);
      checkOutput("w64.p1_dmem", dmemOut64,        ~64'hDEAD_BEEF_0000_0011);
      checkOutput("w64.p1_dest", 64'(destOut64),   64'h11);
      checkOutput("w64.p1_occ",  64'(occ64),       64'd1);
      drive64(1'b1, 64'hCAFE_F00D_0000_0022, 5'h12, 1'b1);
      checkOutput("w64.p2_alu",  aluOut64,         64'hCAFE_F00D_0000_0022);
      checkOutput("w64.p2_dest", 64'(destOut64),   64'h12);
      checkOutput("w64.p2_rdy",  64'(inReady64),   64'd1);
      drive64(1'b1, 64'h8000_0000_0000_0033, 5'h13, 1'b1);
      checkOutput("w64.p3_alu",  aluOut64,         64'h8000_0000_0000_0033);
      checkOutput("w64.p3_memr", 64'(memROut64),   64'd1);
      checkOutput("w64.p3_dest", 64'(destOut64),   64'h13);
      drive64(1'b0, 64'h0, 5'h0, 1'b1);
      checkOutput("w64.end_valid", 64'(outValid64), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
